// File: rtl/memoria_dados_resp.sv
// rtl/memoria_dados_resp.sv - word-addressed data memory responder with fixed access latency
//
// Purpose:
//   Serves one word read or write per LeMem/EscMem request from the multicycle
//   controller. A request accepted in OCIOSO (or in RESPONDE, back-to-back) waits
//   LATENCIA cycles in ESPERA, then spends exactly one cycle in RESPONDE where
//   Pronto pulses. Read data is loaded into DadoLido on entry to RESPONDE, so it is
//   valid while Pronto is high and is held until the next accepted read.
//   Writes commit on the clock edge that ends RESPONDE.
//
// Optional feature (macro MEM_ALINHAMENTO_EN):
//   When defined, an accepted request with Endereco[1:0] != 0 sets Erro. A
//   misaligned write still completes with Pronto but leaves memory untouched;
//   a misaligned read returns zero. When undefined, Endereco[1:0] is ignored.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   LeMem     in   read request strobe (level)
//   EscMem    in   write request strobe (level)
//   Endereco  in   byte address [31:0]; word index = Endereco[log2(PROF)+1:2]
//   DadoEsc   in   write data [LARGURA-1:0]
//   DadoLido  out  read data [LARGURA-1:0]
//   Pronto    out  one-cycle completion pulse
//   Ocupado   out  request in flight (ESPERA)
//   Erro      out  sticky illegal-request flag, cleared only by reset

module memoria_dados_resp #(
  parameter int LARGURA  = 32,
  parameter int PROF     = 64,
  parameter int LATENCIA = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               LeMem,
  input  logic               EscMem,
  input  logic [31:0]        Endereco,
  input  logic [LARGURA-1:0] DadoEsc,
  output logic [LARGURA-1:0] DadoLido,
  output logic               Pronto,
  output logic               Ocupado,
  output logic               Erro
);

  localparam int IW = $clog2(PROF);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESPERA   = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               op_esc_q, op_esc_d;
  logic [LARGURA-1:0] dado_q, dado_d;
  logic [LARGURA-1:0] lido_q, lido_d;
  logic               erro_q, erro_d;
`ifdef MEM_ALINHAMENTO_EN
  logic               desal_q, desal_d;
`endif

  logic [LARGURA-1:0] mem_q [PROF];
  logic               mem_we;
  logic               aceita;
  logic [IW-1:0]      idx_req;

  // Bits above the index and (without the alignment check) the byte offset are
  // intentionally dropped; addresses wrap modulo PROF words.
  logic unused_endereco;
  assign unused_endereco = ^{Endereco[31:IW+2], Endereco[1:0]};

  assign idx_req = Endereco[IW+1:2];

  // A new request may be taken whenever no access is waiting.
  assign aceita = (estado_q == OCIOSO) || (estado_q == RESPONDE);

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    op_esc_d = op_esc_q;
    dado_d   = dado_q;
    lido_d   = lido_q;
    erro_d   = erro_q;
    mem_we   = 1'b0;
`ifdef MEM_ALINHAMENTO_EN
    desal_d  = desal_q;
`endif

    case (estado_q)
      ESPERA: begin
        if (cnt_q == 4'd1) begin
          estado_d = RESPONDE;
          // Load read data on entry to RESPONDE so it is valid alongside Pronto.
          if (!op_esc_q) begin
`ifdef MEM_ALINHAMENTO_EN
            lido_d = desal_q ? '0 : mem_q[idx_q];
`else
            lido_d = mem_q[idx_q];
`endif
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPONDE: begin
        estado_d = OCIOSO;
`ifdef MEM_ALINHAMENTO_EN
        mem_we = op_esc_q && !desal_q;
`else
        mem_we = op_esc_q;
`endif
      end
      default: estado_d = OCIOSO;
    endcase

    // Request acceptance overrides the RESPONDE -> OCIOSO return (back-to-back).
    if (aceita) begin
      if (LeMem && EscMem) begin
        erro_d = 1'b1;
      end else if (LeMem || EscMem) begin
        estado_d = ESPERA;
        cnt_d    = 4'(LATENCIA);
        idx_d    = idx_req;
        op_esc_d = EscMem;
        if (EscMem) begin
          dado_d = DadoEsc;
        end
`ifdef MEM_ALINHAMENTO_EN
        desal_d = |Endereco[1:0];
        if (|Endereco[1:0]) begin
          erro_d = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      idx_q    <= '0;
      op_esc_q <= 1'b0;
      dado_q   <= '0;
      lido_q   <= '0;
      erro_q   <= 1'b0;
`ifdef MEM_ALINHAMENTO_EN
      desal_q  <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      op_esc_q <= op_esc_d;
      dado_q   <= dado_d;
      lido_q   <= lido_d;
      erro_q   <= erro_d;
`ifdef MEM_ALINHAMENTO_EN
      desal_q  <= desal_d;
`endif
    end
  end

  // Storage is not cleared by reset; a reset coinciding with RESPONDE drops the write.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[idx_q] <= dado_q;
    end
  end

  assign DadoLido = lido_q;
  assign Pronto   = (estado_q == RESPONDE);
  assign Ocupado  = (estado_q == ESPERA);
  assign Erro     = erro_q;

endmodule

// File: tb/tb_memoria_dados_resp.sv
// tb/tb_memoria_dados_resp.sv - directed self-checking bench for memoria_dados_resp
module tb_memoria_dados_resp;

  localparam int LARGURA  = 32;
  localparam int PROF     = 64;
  localparam int LATENCIA = 2;

  logic               clock;
  logic               reset;
  logic               LeMem;
  logic               EscMem;
  logic [31:0]        Endereco;
  logic [LARGURA-1:0] DadoEsc;
  logic [LARGURA-1:0] DadoLido;
  logic               Pronto;
  logic               Ocupado;
  logic               Erro;

  int pass_cnt;
  int total_cnt;

  memoria_dados_resp #(
    .LARGURA (LARGURA),
    .PROF    (PROF),
    .LATENCIA(LATENCIA)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .LeMem   (LeMem),
    .EscMem  (EscMem),
    .Endereco(Endereco),
    .DadoEsc (DadoEsc),
    .DadoLido(DadoLido),
    .Pronto  (Pronto),
    .Ocupado (Ocupado),
    .Erro    (Erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a one-cycle strobe; returns at the negedge after the sampling edge.
  task automatic issue(input logic le, input logic esc, input logic [31:0] addr,
                       input logic [31:0] data);
    @(negedge clock);
    LeMem = le; EscMem = esc; Endereco = addr; DadoEsc = data;
    @(negedge clock);
    LeMem = 1'b0; EscMem = 1'b0;
  endtask

  // Number of further negedges until Pronto is seen (99 if never within budget).
  task automatic wait_pronto(output int ciclos);
    ciclos = 99;
    for (int i = 0; i < 20; i++) begin
      if (Pronto === 1'b1) begin
        ciclos = i;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    LeMem = 1'b0; EscMem = 1'b0; Endereco = '0; DadoEsc = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({DadoLido, Pronto, Ocupado, Erro} !== {32'h0, 3'b000})
      $display("FAIL reset_outputs: got DadoLido=%h P=%b O=%b E=%b, want all 0",
               DadoLido, Pronto, Ocupado, Erro);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    int c;
    issue(1'b0, 1'b1, 32'h08, 32'hDEADBEEF);
    total_cnt++;
    if (Ocupado !== 1'b1) $display("FAIL wr_busy: got %b want 1", Ocupado);
    else pass_cnt++;
    wait_pronto(c);
    total_cnt++;
    if (c !== LATENCIA) $display("FAIL wr_latency: got %0d want %0d", c, LATENCIA);
    else pass_cnt++;
    total_cnt++;
    if (Ocupado !== 1'b0) $display("FAIL wr_busy_in_pronto: got %b want 0", Ocupado);
    else pass_cnt++;
    total_cnt++;
    if (DadoLido !== 32'h0) $display("FAIL wr_no_lido_change: got %h want 0", DadoLido);
    else pass_cnt++;
    issue(1'b1, 1'b0, 32'h08, 32'h0);
    wait_pronto(c);
    total_cnt++;
    if (c !== LATENCIA) $display("FAIL rd_latency: got %0d want %0d", c, LATENCIA);
    else pass_cnt++;
    total_cnt++;
    if (DadoLido !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", DadoLido);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (Pronto !== 1'b0) $display("FAIL pronto_one_cycle: got %b want 0", Pronto);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int c;
    issue(1'b0, 1'b1, 32'h100, 32'h1234);
    wait_pronto(c);
    issue(1'b1, 1'b0, 32'h000, 32'h0);
    wait_pronto(c);
    total_cnt++;
    if (DadoLido !== 32'h1234) $display("FAIL wrap_data: got %h want 00001234", DadoLido);
    else pass_cnt++;
  endtask

  task automatic test_strobe_busy();
    int n;
    n = 0;
    issue(1'b0, 1'b1, 32'h04, 32'hCAFE0004);
    LeMem = 1'b1; Endereco = 32'h0C;
    if (Pronto === 1'b1) n++;
    @(negedge clock);
    LeMem = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (Pronto === 1'b1) n++;
      @(negedge clock);
    end
    total_cnt++;
    if (n !== 1) $display("FAIL busy_single_pronto: got %0d pulses want 1", n);
    else pass_cnt++;
    total_cnt++;
    if (DadoLido !== 32'h1234) $display("FAIL busy_lido_hold: got %h want 00001234", DadoLido);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    int c;
    int n;
    n = 0;
    issue(1'b0, 1'b1, 32'h10, 32'h0BADF00D);
    wait_pronto(c);
    issue(1'b0, 1'b1, 32'h10, 32'h11111111);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (Pronto === 1'b1) n++;
      @(negedge clock);
    end
    total_cnt++;
    if (n !== 0 || Ocupado !== 1'b0)
      $display("FAIL abort_no_pronto: got pulses=%0d O=%b want 0/0", n, Ocupado);
    else pass_cnt++;
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    wait_pronto(c);
    total_cnt++;
    if (DadoLido !== 32'h0BADF00D) $display("FAIL abort_mem_kept: got %h want 0badf00d", DadoLido);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c;
    issue(1'b0, 1'b1, 32'h30, 32'h00000077);
    wait_pronto(c);
    LeMem = 1'b1; Endereco = 32'h30;
    @(negedge clock);
    LeMem = 1'b0;
    total_cnt++;
    if (Ocupado !== 1'b1 || Pronto !== 1'b0)
      $display("FAIL b2b_accept: got O=%b P=%b want 1/0", Ocupado, Pronto);
    else pass_cnt++;
    wait_pronto(c);
    total_cnt++;
    if (c !== LATENCIA || DadoLido !== 32'h77)
      $display("FAIL b2b_read: got lat=%0d data=%h want %0d/00000077", c, DadoLido, LATENCIA);
    else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_illegal();
    int c;
    issue(1'b0, 1'b1, 32'h20, 32'h0000A5A5);
    wait_pronto(c);
    issue(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF);
    total_cnt++;
    if (Erro !== 1'b1 || Ocupado !== 1'b0)
      $display("FAIL illegal_flag: got E=%b O=%b want 1/0", Erro, Ocupado);
    else pass_cnt++;
    total_cnt++;
    if (DadoLido !== 32'h77) $display("FAIL illegal_lido_hold: got %h want 00000077", DadoLido);
    else pass_cnt++;
    issue(1'b1, 1'b0, 32'h20, 32'h0);
    wait_pronto(c);
    total_cnt++;
    if (DadoLido !== 32'hA5A5 || Erro !== 1'b1)
      $display("FAIL illegal_mem_kept: got %h E=%b want 0000a5a5/1", DadoLido, Erro);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (Erro !== 1'b0) $display("FAIL erro_cleared: got %b want 0", Erro);
    else pass_cnt++;
  endtask

`ifdef MEM_ALINHAMENTO_EN
  task automatic test_alinhamento();
    int c;
    issue(1'b0, 1'b1, 32'h06, 32'h00000055);
    total_cnt++;
    if (Erro !== 1'b1) $display("FAIL align_erro: got %b want 1", Erro);
    else pass_cnt++;
    wait_pronto(c);
    total_cnt++;
    if (c !== LATENCIA) $display("FAIL align_pronto: got %0d want %0d", c, LATENCIA);
    else pass_cnt++;
    issue(1'b1, 1'b0, 32'h04, 32'h0);
    wait_pronto(c);
    total_cnt++;
    if (DadoLido !== 32'hCAFE0004) $display("FAIL align_wr_suppressed: got %h want cafe0004", DadoLido);
    else pass_cnt++;
    issue(1'b1, 1'b0, 32'h06, 32'h0);
    wait_pronto(c);
    total_cnt++;
    if (DadoLido !== 32'h0) $display("FAIL align_rd_zero: got %h want 0", DadoLido);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_write_read();
    test_wrap();
    test_strobe_busy();
    test_reset_mid_access();
    test_back_to_back();
    test_illegal();
`ifdef MEM_ALINHAMENTO_EN
    test_alinhamento();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
